// File: rtl/ioctl_bram_loader.sv
// Buffers the MiSTer HPS ioctl download stream in a small FIFO and drains it into a BRAM write port.
// Optional LOADER_CHECKSUM_EN adds a running byte checksum output.
module ioctl_bram_loader #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 8,
    parameter int unsigned INDEX = 0,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [26:0]   ioctl_addr,
    input  logic [DW-1:0] ioctl_dout,
    output logic          ioctl_wait,
    input  logic          bram_busy,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_data,
    output logic          bram_wren,
    output logic          loading,
    output logic          load_done,
    output logic [AW:0]   byte_count,
    output logic          overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = AW + DW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [26:0]   IMG_SIZE = 27'(2 ** AW);
    localparam logic [AW:0]   BC_MAX   = (AW + 1)'(2 ** AW);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 1);

    logic [EW-1:0]  mem_q [DEPTH];

    logic [1:0]     state_q,   state_d;
    logic [PW-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]  count_q,   count_d;
    logic           wren_q,    wren_d;
    logic [AW-1:0]  addr_q,    addr_d;
    logic [DW-1:0]  data_q,    data_d;
    logic           loading_q, loading_d;
    logic           done_q,    done_d;
    logic [AW:0]    bc_q,      bc_d;
    logic           ovf_q,     ovf_d;
    logic           wait_q,    wait_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0]  csum_q,    csum_d;
`endif

    logic           push_c;
    logic           pop_c;
    logic           drop_c;
    logic [EW-1:0]  head_c;

    // State and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            bc_q      <= '0;
            ovf_q     <= 1'b0;
            wait_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            bc_q      <= bc_d;
            ovf_q     <= ovf_d;
            wait_q    <= wait_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // FIFO storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk_sys) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {ioctl_addr[AW-1:0], ioctl_dout};
        end
    end

    // Next-state, FIFO control and write-port logic
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        wren_d    = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        bc_d      = bc_q;
        ovf_d     = ovf_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        head_c    = mem_q[rd_ptr_q];

        push_c = (state_q == S_LOAD) && ioctl_wr && (ioctl_addr < IMG_SIZE)
                 && (count_q != FULL_LVL);
        drop_c = (state_q == S_LOAD) && ioctl_wr
                 && ((ioctl_addr >= IMG_SIZE) || (count_q == FULL_LVL));
        pop_c  = ((state_q == S_LOAD) || (state_q == S_FLUSH))
                 && (count_q != '0) && !bram_busy;

        case (state_q)
            S_IDLE: begin
                if (ioctl_download && (ioctl_index == 8'(INDEX))) begin
                    state_d = S_LOAD;
                    bc_d    = '0;
                    ovf_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LOAD: begin
                if (!ioctl_download) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Pushes are closed here, so an empty FIFO also means no pop this cycle
                if (count_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (drop_c) begin
            ovf_d = 1'b1;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            wren_d   = 1'b1;
            addr_d   = head_c[EW-1:DW];
            data_d   = head_c[DW-1:0];
            if (bc_q != BC_MAX) begin
                bc_d = bc_q + (AW + 1)'(1);
            end
`ifdef LOADER_CHECKSUM_EN
            csum_d = csum_q + head_c[DW-1:0];
`endif
        end
        count_d = count_q + CW'(push_c) - CW'(pop_c);

        loading_d = (state_d == S_LOAD) || (state_d == S_FLUSH);
        done_d    = (state_d == S_DONE);
        wait_d    = (state_d == S_LOAD) && (count_d >= WAIT_LVL);
    end

    assign ioctl_wait = wait_q;
    assign bram_wren  = wren_q;
    assign bram_addr  = addr_q;
    assign bram_data  = data_q;
    assign loading    = loading_q;
    assign load_done  = done_q;
    assign byte_count = bc_q;
    assign overflow   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_ioctl_bram_loader.sv
// Directed scoreboard bench for ioctl_bram_loader (AW=10, DW=8, INDEX=0, DEPTH=4).
module tb_ioctl_bram_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        bram_busy;
    logic [9:0]  bram_addr;
    logic [7:0]  bram_data;
    logic        bram_wren;
    logic        loading;
    logic        load_done;
    logic [10:0] byte_count;
    logic        overflow;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
    logic [7:0]  done_cs;
`endif

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
        int         cyc;
        bit         lat;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  wren_cnt = 0;
    int  done_cnt = 0;
    int  unexpected = 0;
    logic [10:0] done_bc;
    logic        done_ovf;

    ioctl_bram_loader #(.AW(10), .DW(8), .INDEX(0), .DEPTH(4)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .bram_busy      (bram_busy),
        .bram_addr      (bram_addr),
        .bram_data      (bram_data),
        .bram_wren      (bram_wren),
        .loading        (loading),
        .load_done      (load_done),
        .byte_count     (byte_count),
        .overflow       (overflow)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: pops the scoreboard on every BRAM write
    always @(negedge clk_sys) begin
        if (bram_wren === 1'b1) begin
            wren_cnt++;
            if (sb.size() == 0) begin
                unexpected++;
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("bram_addr", 32'(bram_addr), 32'(e.a));
                check("bram_data", 32'(bram_data), 32'(e.d));
                if (e.lat) check("write_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (load_done === 1'b1) begin
            done_cnt++;
            done_bc  = byte_count;
            done_ovf = overflow;
`ifdef LOADER_CHECKSUM_EN
            done_cs  = checksum;
`endif
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_load(input logic [7:0] idx);
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        tick();
    endtask

    // One HPS strobe; honours ioctl_wait with a bounded stall
    task automatic wr_byte(input int a, input logic [7:0] d, input bit expect_wr, input bit lat);
        sb_t e;
        for (int i = 0; i < 100 && ioctl_wait === 1'b1; i++) tick();
        if (ioctl_wait !== 1'b0) check("wait_release", 32'(ioctl_wait), 32'd0);
        ioctl_wr   = 1'b1;
        ioctl_addr = 27'(a);
        ioctl_dout = d;
        if (expect_wr) begin
            e.a = 10'(a);
            e.d = d;
            e.cyc = cyc + 2;
            e.lat = lat;
            sb.push_back(e);
        end
        tick();
        ioctl_wr = 1'b0;
    endtask

    // Drop download and wait (bounded) for exactly one load_done pulse
    task automatic finish_load();
        int prev;
        prev = done_cnt;
        ioctl_download = 1'b0;
        for (int i = 0; i < 64 && done_cnt == prev; i++) tick();
        check("load_done_seen", 32'(done_cnt), 32'(prev + 1));
        repeat (4) tick();
        check("load_done_single", 32'(done_cnt), 32'(prev + 1));
        check("loading_after_done", 32'(loading), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("unexpected_writes", 32'(unexpected), 32'd0);
    endtask

    initial begin
        int prev_done;
        int prev_wren;

        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        bram_busy = 1'b0;
        repeat (3) tick();
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_wren", 32'(bram_wren), 32'd0);
        check("rst_addr", 32'(bram_addr), 32'd0);
        check("rst_data", 32'(bram_data), 32'd0);
        check("rst_loading", 32'(loading), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_bc", 32'(byte_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        // 16-byte image, no contention
        start_load(8'd0);
        check("loading_in_load", 32'(loading), 32'd1);
        for (int i = 0; i < 16; i++) wr_byte(i, 8'(8'hA0 + i), 1'b1, 1'b1);
        finish_load();
        check("t1_bc", 32'(done_bc), 32'd16);
        check("t1_ovf", 32'(done_ovf), 32'd0);
        check("t1_wren_cnt", 32'(wren_cnt), 32'd16);

        // Foreign index is ignored
        prev_done = done_cnt;
        prev_wren = wren_cnt;
        start_load(8'd1);
        for (int i = 0; i < 8; i++) begin
            wr_byte(i, 8'(8'h30 + i), 1'b0, 1'b0);
            check("t2_loading", 32'(loading), 32'd0);
        end
        ioctl_download = 1'b0;
        repeat (6) tick();
        check("t2_done", 32'(done_cnt), 32'(prev_done));
        check("t2_wren", 32'(wren_cnt), 32'(prev_wren));
        check("t2_unexpected", 32'(unexpected), 32'd0);

        // BRAM busy for 10 cycles while the HPS streams
        bram_busy = 1'b1;
        prev_wren = wren_cnt;
        start_load(8'd0);
        for (int i = 0; i < 3; i++) wr_byte(16'h100 + i, 8'(8'h50 + i), 1'b1, 1'b0);
        check("t3_wait_at_3", 32'(ioctl_wait), 32'd1);
        repeat (6) tick();
        check("t3_wait_held", 32'(ioctl_wait), 32'd1);
        check("t3_no_write_busy", 32'(wren_cnt), 32'(prev_wren));
        bram_busy = 1'b0;
        for (int i = 3; i < 8; i++) wr_byte(16'h100 + i, 8'(8'h50 + i), 1'b1, 1'b0);
        finish_load();
        check("t3_bc", 32'(done_bc), 32'd8);
        check("t3_ovf", 32'(done_ovf), 32'd0);

        // Out-of-range byte is dropped and flagged
        start_load(8'd0);
        wr_byte(0, 8'h11, 1'b1, 1'b0);
        wr_byte(1, 8'h22, 1'b1, 1'b0);
        wr_byte(1024, 8'h55, 1'b0, 1'b0);
        check("t4_ovf_now", 32'(overflow), 32'd1);
        wr_byte(1023, 8'h33, 1'b1, 1'b0);
        finish_load();
        check("t4_bc", 32'(done_bc), 32'd3);
        check("t4_ovf", 32'(done_ovf), 32'd1);

        // Reset with 3 bytes buffered aborts the load
        bram_busy = 1'b1;
        start_load(8'd0);
        check("t5_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) wr_byte(i, 8'(8'hC0 + i), 1'b1, 1'b0);
        reset = 1'b1;
        ioctl_download = 1'b0;
        sb.delete();
        prev_done = done_cnt;
        tick();
        check("t5_wren", 32'(bram_wren), 32'd0);
        check("t5_loading", 32'(loading), 32'd0);
        check("t5_wait", 32'(ioctl_wait), 32'd0);
        check("t5_bc", 32'(byte_count), 32'd0);
        check("t5_addr", 32'(bram_addr), 32'd0);
        reset = 1'b0;
        bram_busy = 1'b0;
        prev_wren = wren_cnt;
        repeat (6) tick();
        check("t5_no_done", 32'(done_cnt), 32'(prev_done));
        check("t5_no_write", 32'(wren_cnt), 32'(prev_wren));
        start_load(8'd0);
        for (int i = 0; i < 4; i++) wr_byte(i + 8, 8'(8'hE0 + i), 1'b1, 1'b1);
        finish_load();
        check("t5_reload_bc", 32'(done_bc), 32'd4);

`ifdef LOADER_CHECKSUM_EN
        start_load(8'd0);
        wr_byte(0, 8'h01, 1'b1, 1'b0);
        wr_byte(1, 8'hFF, 1'b1, 1'b0);
        wr_byte(2, 8'h10, 1'b1, 1'b0);
        finish_load();
        check("checksum", 32'(done_cs), 32'h10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
